// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key decoder: FSM state encoding, letter code
// width and sentinel, unit counter width and default timing parameters.
package morse_pkg;

  localparam int unsigned CodeW = 5;
  localparam logic [CodeW-1:0] CodeSentinel = 5'b00001;
  localparam int unsigned UnitW = 4;

  localparam int unsigned DefTickDiv        = 50000;
  localparam int unsigned DefDashMinUnits   = 2;
  localparam int unsigned DefLetterGapUnits = 3;
  localparam int unsigned DefWordGapUnits   = 7;

  typedef enum logic [2:0] {
    StIdle,
    StMark,
    StSpace,
    StGap,
    StDrop
  } morse_state_e;

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler plus saturating unit counter.
//   clk, rst_n : clock, async active-low reset
//   restart    : clear prescaler and unit count (wins over enable)
//   enable     : advance the prescaler
//   tick       : high on the cycle a unit boundary is crossed
//   units      : completed units since last restart, saturating at 15
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV = DefTickDiv
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             enable,
  output logic             tick,
  output logic [UnitW-1:0] units
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic [UnitW-1:0] units_q, units_d;

  assign tick  = enable && !restart && (pre_q == PreLast);
  assign units = units_q;

  always_comb begin
    pre_d   = pre_q;
    units_d = units_q;
    if (restart) begin
      pre_d   = '0;
      units_d = '0;
    end else if (enable) begin
      if (pre_q == PreLast) begin
        pre_d = '0;
        if (units_q != '1) begin
          units_d = units_q + 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      units_q <= '0;
    end else begin
      pre_q   <= pre_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key decoder: synchronizes a raw key, times presses and releases in
// Morse units and assembles letters as a leading-1 sentinel code.
//   clk, rst_n : clock, async active-low reset
//   key_in     : raw asynchronous key, 1 = pressed
//   shift      : last decoded letter code, held until the next letter
//   sym_valid  : one-cycle strobe when shift is updated
//   word_gap   : one-cycle strobe at the end of a word
//   err        : one-cycle strobe when a letter exceeds 4 elements
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV         = DefTickDiv,
  parameter int unsigned DASH_MIN_UNITS   = DefDashMinUnits,
  parameter int unsigned LETTER_GAP_UNITS = DefLetterGapUnits,
  parameter int unsigned WORD_GAP_UNITS   = DefWordGapUnits
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_in,
  output logic [CodeW-1:0] shift,
  output logic             sym_valid,
  output logic             word_gap,
  output logic             err
);

  localparam logic [UnitW-1:0] DashMin    = UnitW'(DASH_MIN_UNITS);
  // The threshold tick is seen while units still holds one less than the gap.
  localparam logic [UnitW-1:0] LetterLast = UnitW'(LETTER_GAP_UNITS - 1);
  localparam logic [UnitW-1:0] WordLast   = UnitW'(WORD_GAP_UNITS - 1);

  logic key_meta_q, key_s_q, key_prev_q;
  logic key_rise, key_fall, key_edge;

  morse_state_e     state_q, state_d;
  logic [CodeW-1:0] acc_q, acc_d;
  logic [CodeW-1:0] shift_q, shift_d;
  logic             sym_valid_q, sym_valid_d;
  logic             word_gap_q, word_gap_d;
  logic             err_q, err_d;

  logic             tick;
  logic [UnitW-1:0] units;

  // key_prev_q resets low so a key held through reset reads as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      key_meta_q <= key_in;
      key_s_q    <= key_meta_q;
      key_prev_q <= key_s_q;
    end
  end

  assign key_rise = key_s_q && !key_prev_q;
  assign key_fall = !key_s_q && key_prev_q;
  assign key_edge = key_rise || key_fall;

  morse_unit_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_unit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (key_edge),
    .enable  (state_q != StIdle),
    .tick    (tick),
    .units   (units)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    shift_d     = shift_q;
    sym_valid_d = 1'b0;
    word_gap_d  = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_rise) begin
          state_d = StMark;
          acc_d   = CodeSentinel;
        end
      end
      StMark: begin
        if (key_fall) begin
          if (acc_q[CodeW-1]) begin
            err_d   = 1'b1;
            state_d = StDrop;
          end else begin
            acc_d   = {acc_q[CodeW-2:0], (units >= DashMin)};
            state_d = StSpace;
          end
        end
      end
      StSpace: begin
        // A press on the threshold cycle continues the current letter.
        if (key_rise) begin
          state_d = StMark;
        end else if (tick && (units == LetterLast)) begin
          shift_d     = acc_q;
          sym_valid_d = 1'b1;
          state_d     = StGap;
        end
      end
      StGap: begin
        if (key_rise) begin
          state_d = StMark;
          acc_d   = CodeSentinel;
        end else if (tick && (units == WordLast)) begin
          word_gap_d = 1'b1;
          state_d    = StIdle;
        end
      end
      StDrop: begin
        // Edges restart the timer, so only an unbroken release gets here.
        if (tick && (units == LetterLast) && !key_s_q) begin
          state_d = StGap;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= CodeSentinel;
      shift_q     <= '0;
      sym_valid_q <= 1'b0;
      word_gap_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      shift_q     <= shift_d;
      sym_valid_q <= sym_valid_d;
      word_gap_q  <= word_gap_d;
      err_q       <= err_d;
    end
  end

  assign shift     = shift_q;
  assign sym_valid = sym_valid_q;
  assign word_gap  = word_gap_q;
  assign err       = err_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
module tb_morse_key_decoder;

  localparam int unsigned TickDiv = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_in;
  logic [4:0] shift;
  logic       sym_valid;
  logic       word_gap;
  logic       err;

  int checks = 0;
  int errors = 0;

  int sym_tot = 0;
  int wg_tot  = 0;
  int err_tot = 0;
  int ovl_tot = 0;

  typedef struct packed {
    logic [2:0]      n;
    logic [5:0][7:0] press;
    logic [7:0]      gap;
    logic [7:0]      rel;
    logic [4:0]      code;
    logic [1:0]      n_sym;
    logic            n_wg;
    logic            n_err;
  } vec_t;

  localparam int NumVec = 14;
  vec_t vecs [NumVec];

  morse_key_decoder #(
    .TICK_DIV         (TickDiv),
    .DASH_MIN_UNITS   (2),
    .LETTER_GAP_UNITS (3),
    .WORD_GAP_UNITS   (7)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .shift     (shift),
    .sym_valid (sym_valid),
    .word_gap  (word_gap),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sym_valid) sym_tot <= sym_tot + 1;
    if (word_gap)  wg_tot  <= wg_tot + 1;
    if (err)       err_tot <= err_tot + 1;
    if ((int'(sym_valid) + int'(word_gap) + int'(err)) > 1) ovl_tot <= ovl_tot + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Hold key_in at v for n cycles; always entered and left on a falling edge.
  task automatic drive(input logic v, input int n);
    key_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    key_in = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  function automatic vec_t mk(input int n, input int p0, input int p1, input int p2,
                              input int p3, input int p4, input int p5, input int gap,
                              input int rel, input logic [4:0] code, input int ns,
                              input int nw, input int ne);
    vec_t v;
    v.n     = 3'(n);
    v.press = {8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
    v.gap   = 8'(gap);
    v.rel   = 8'(rel);
    v.code  = code;
    v.n_sym = 2'(ns);
    v.n_wg  = 1'(nw);
    v.n_err = 1'(ne);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    for (int i = 0; i < int'(v.n); i++) begin
      drive(1'b1, int'(v.press[i]));
      drive(1'b0, (i == int'(v.n) - 1) ? int'(v.rel) : int'(v.gap));
    end
  endtask

  task automatic run_check(input string tag, input vec_t v);
    int s0, w0, e0;
    s0 = sym_tot;
    w0 = wg_tot;
    e0 = err_tot;
    apply(v);
    check({tag, "_shift"}, int'(shift), int'(v.code));
    check({tag, "_sym"}, sym_tot - s0, int'(v.n_sym));
    check({tag, "_wgap"}, wg_tot - w0, int'(v.n_wg));
    check({tag, "_err"}, err_tot - e0, int'(v.n_err));
  endtask

  initial begin
    int s0, w0, e0;
    // One unit = 4 cycles: dot = 4, dash = 12, letter gap = 12, word gap = 28.
    vecs[0]  = mk(2, 4, 12, 0, 0, 0, 0, 4, 16, 5'b00101, 1, 0, 0);    // A
    vecs[1]  = mk(4, 4, 12, 4, 4, 0, 0, 4, 32, 5'b10100, 1, 1, 0);    // .-.. then word
    vecs[2]  = mk(1, 4, 0, 0, 0, 0, 0, 4, 32, 5'b00010, 1, 1, 0);     // E then word
    vecs[3]  = mk(1, 12, 0, 0, 0, 0, 0, 4, 16, 5'b00011, 1, 0, 0);    // T
    vecs[4]  = mk(1, 70, 0, 0, 0, 0, 0, 4, 16, 5'b00011, 1, 0, 0);    // saturated
    vecs[5]  = mk(1, 2, 0, 0, 0, 0, 0, 4, 16, 5'b00010, 1, 0, 0);     // sub-unit press
    vecs[6]  = mk(4, 12, 12, 12, 12, 0, 0, 4, 16, 5'b11111, 1, 0, 0); // ----
    vecs[7]  = mk(1, 8, 0, 0, 0, 0, 0, 4, 16, 5'b00010, 1, 0, 0);     // 1 unit: dot
    vecs[8]  = mk(1, 9, 0, 0, 0, 0, 0, 4, 16, 5'b00011, 1, 0, 0);     // 2 units: dash
    vecs[9]  = mk(2, 4, 4, 0, 0, 0, 0, 12, 16, 5'b00100, 1, 0, 0);    // press on gap tick
    vecs[10] = mk(2, 4, 4, 0, 0, 0, 0, 13, 16, 5'b00010, 2, 0, 0);    // one cycle later
    vecs[11] = mk(2, 4, 12, 0, 0, 0, 0, 11, 16, 5'b00101, 1, 0, 0);   // just under gap
    vecs[12] = mk(5, 4, 4, 4, 4, 4, 0, 4, 32, 5'b00000, 0, 1, 1);     // five dots
    vecs[13] = mk(6, 4, 4, 4, 4, 4, 4, 4, 32, 5'b00000, 0, 1, 1);     // six dots

    rst_n  = 1'b0;
    key_in = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_shift", int'(shift), 0);
    check("rst_sym", int'(sym_valid), 0);
    check("rst_wgap", int'(word_gap), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < NumVec; i++) begin
      do_reset();
      run_check($sformatf("v%0d", i), vecs[i]);
    end

    // Letter following a dropped one decodes normally.
    run_check("after_drop_T", mk(1, 12, 0, 0, 0, 0, 0, 4, 16, 5'b00011, 1, 0, 0));

    // Reset in the middle of a press abandons the letter.
    do_reset();
    s0 = sym_tot;
    w0 = wg_tot;
    e0 = err_tot;
    drive(1'b1, 6);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    key_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midmark_shift", int'(shift), 0);
    check("midmark_strobes", (sym_tot - s0) + (wg_tot - w0) + (err_tot - e0), 0);
    run_check("midmark_dot", mk(1, 4, 0, 0, 0, 0, 0, 4, 16, 5'b00010, 1, 0, 0));

    // Key held across reset release counts as a fresh press.
    rst_n  = 1'b0;
    key_in = 1'b1;
    repeat (3) @(negedge clk);
    s0 = sym_tot;
    rst_n = 1'b1;
    drive(1'b1, 6);
    drive(1'b0, 16);
    check("held_rst_shift", int'(shift), 5'b00010);
    check("held_rst_sym", sym_tot - s0, 1);

    repeat (2) @(negedge clk);
    check("strobe_overlap", ovl_tot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
MORSE_KEY_DECODER -- requirements
Module: morse_key_decoder

Interface
REQ-001 The block SHALL expose parameter TICK_DIV, default 50000, giving the clock cycles per Morse time unit.
REQ-002 The block SHALL expose parameter DASH_MIN_UNITS, default 2, the press length in units at or above which an element is a dash.
REQ-003 The block SHALL expose parameter LETTER_GAP_UNITS, default 3, the release length in units that closes a letter.
REQ-004 The block SHALL expose parameter WORD_GAP_UNITS, default 7, the release length in units that closes a word.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port key_in, input, 1 bit: raw asynchronous Morse key, 1 means pressed.
REQ-009 Port shift, output, 5 bits: decoded letter code, held until the next letter.
REQ-010 Port sym_valid, output, 1 bit: one-cycle strobe that marks a new shift value.
REQ-011 Port word_gap, output, 1 bit: one-cycle strobe at the end of a word.
REQ-012 Port err, output, 1 bit: one-cycle strobe when a letter exceeds 4 elements.

Function
REQ-013 key_in SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized key_s.
REQ-014 The prescaler SHALL emit a unit tick every TICK_DIV cycles and SHALL restart from zero on every edge of key_s.
REQ-015 The unit counter SHALL be 4 bits wide, SHALL increment on each unit tick, SHALL saturate at 15, and SHALL clear on every key_s edge.
REQ-016 The FSM states SHALL be IDLE, MARK, SPACE, GAP and DROP.
REQ-017 From IDLE, GAP or SPACE, a rising edge of key_s SHALL enter MARK.
REQ-018 Leaving IDLE or GAP SHALL reset the letter accumulator to 5'b00001.
REQ-019 On a falling edge of key_s in MARK, the accumulator SHALL shift left by one and take 1 (dash) into the LSB if the unit count is at least DASH_MIN_UNITS, otherwise 0 (dot); the FSM SHALL then enter SPACE.
REQ-020 A press shorter than one unit SHALL decode as a dot.
REQ-021 A saturated press count SHALL decode as a dash.
REQ-022 If a falling edge arrives in MARK while the accumulator MSB is already 1, the letter SHALL be discarded, err SHALL pulse for one cycle, and the FSM SHALL enter DROP.
REQ-023 In SPACE, the unit tick that makes the count equal LETTER_GAP_UNITS SHALL load shift from the accumulator on the next cycle, with sym_valid high for exactly that cycle, and the FSM SHALL enter GAP.
REQ-024 In GAP, the unit count reaching WORD_GAP_UNITS SHALL pulse word_gap for one cycle and return the FSM to IDLE.
REQ-025 In GAP, counting SHALL continue from the letter gap and SHALL NOT restart at GAP entry.
REQ-026 In DROP, the FSM SHALL ignore elements until a release of LETTER_GAP_UNITS units, then enter GAP without pulsing sym_valid.
REQ-027 In DROP, any key edge SHALL restart the gap count.
REQ-028 A key rising edge on the same cycle as a gap-threshold tick SHALL take priority: the FSM enters MARK and no strobe fires.
REQ-029 sym_valid, word_gap and err SHALL never assert on the same cycle.
REQ-030 Code encoding SHALL be a leading-1 sentinel followed by elements, oldest first (dot=0, dash=1); e.g. "E" = 00010, "T" = 00011, "A" = 00101.
REQ-031 The all-ones code 11111 SHALL be a valid decode ("----" is not a letter, but its code is emitted anyway).

Reset
REQ-032 While rst_n is low, the FSM SHALL be IDLE, shift SHALL be 5'b00000, sym_valid, word_gap and err SHALL be 0, the accumulator SHALL be 5'b00001, and the counters and synchronizer SHALL be cleared.
REQ-033 A reset during MARK, SPACE, GAP or DROP SHALL abandon the partial letter with no strobe on release.
REQ-034 After reset release, a key already held SHALL be treated as a rising edge once synchronized.

Structure
REQ-035 Package morse_pkg SHALL hold the FSM state enum, the code width (5), the sentinel value 5'b00001, and the default unit parameters.
REQ-036 The prescaler and the saturating unit counter SHALL be one sub-module, morse_unit_timer, with inputs restart and enable and outputs tick and units[3:0].

Verification (TICK_DIV=4 for simulation)
REQ-037 Pressing 4 cycles, releasing 4, pressing 12, then releasing 16 cycles SHALL give shift=00101 with one sym_valid pulse.
REQ-038 The sequence dot, dash, dot, dot, each separated by 1-unit gaps, followed by a 3-unit release SHALL give shift=10100, then word_gap after 7 units total release.
REQ-039 Five dots at 1-unit spacing SHALL give one err pulse and no sym_valid; the next letter "T" SHALL decode to 00011.
REQ-040 A 70-cycle press (saturated count) SHALL decode as a dash, giving shift=00011.
REQ-041 Asserting rst_n low mid-MARK and then releasing it SHALL give shift=00000 and no strobes; a subsequent dot SHALL decode to 00010.
REQ-042 A key press on the exact cycle of the letter-gap tick SHALL produce no sym_valid, and the new element SHALL be appended to the current letter.
